// File: rtl/life_board_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : life_board_arbiter_if
// Brief    : Request/grant/data bundle between the board arbiter and its users
// Revision : 1.0
// ----------------------------------------------------------------------------
interface life_board_arbiter_if #(
    parameter int ADDR_W = 7
);
    logic              vblank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_data;
    logic              disp_valid;
    logic              disp_miss;
    logic              upd_req;
    logic [ADDR_W-1:0] upd_addr;
    logic              upd_gnt;
    logic              upd_data;
    logic              upd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              wr_gnt;
    logic              starve_flag;

    modport master (
        output vblank, disp_req, disp_addr, upd_req, upd_addr,
               wr_req, wr_addr, wr_data,
        input  disp_data, disp_valid, disp_miss, upd_gnt, upd_data,
               upd_valid, wr_gnt, starve_flag
    );

    modport slave (
        input  vblank, disp_req, disp_addr, upd_req, upd_addr,
               wr_req, wr_addr, wr_data,
        output disp_data, disp_valid, disp_miss, upd_gnt, upd_data,
               upd_valid, wr_gnt, starve_flag
    );
endinterface
`default_nettype wire

// File: rtl/life_board_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : life_board_arbiter
// Brief    : Game-of-Life cell store with display-priority, starvation-safe
//            single-slot arbitration between display, update and write paths
// Revision : 1.0
// ----------------------------------------------------------------------------
module life_board_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int DEPTH          = 128,
    parameter int STARVE_LIMIT   = 15,
    parameter bit WR_VBLANK_ONLY = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    life_board_arbiter_if.slave bus
);
    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int c_IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        RR_UPD = 1'b0,
        RR_WR  = 1'b1
    } rr_t;

    logic [DEPTH-1:0]   r_cells;
    rr_t                r_rr;
    rr_t                w_rr_next;
    logic [c_CNT_W-1:0] r_upd_cnt;
    logic [c_CNT_W-1:0] r_wr_cnt;
    logic [c_CNT_W-1:0] w_upd_cnt_next;
    logic [c_CNT_W-1:0] w_wr_cnt_next;
    logic               r_disp_data;
    logic               r_disp_valid;
    logic               r_upd_data;
    logic               r_upd_valid;
    logic               r_starve;

    logic w_upd_elig, w_wr_elig, w_upd_ovr, w_wr_ovr;
    logic w_upd_gnt, w_wr_gnt, w_disp_gnt, w_disp_miss, w_override;
    logic w_disp_in, w_upd_in, w_wr_in;

    logic [c_IDX_W-1:0] w_disp_idx, w_upd_idx, w_wr_idx;
    assign w_disp_idx = bus.disp_addr[c_IDX_W-1:0];
    assign w_upd_idx  = bus.upd_addr[c_IDX_W-1:0];
    assign w_wr_idx   = bus.wr_addr[c_IDX_W-1:0];

    // A fully populated address space has no out-of-range addresses.
    generate
        if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
            assign w_disp_in = 1'b1;
            assign w_upd_in  = 1'b1;
            assign w_wr_in   = 1'b1;
        end else begin : g_partial_range
            localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);
            assign w_disp_in = (bus.disp_addr < c_DEPTH);
            assign w_upd_in  = (bus.upd_addr  < c_DEPTH);
            assign w_wr_in   = (bus.wr_addr   < c_DEPTH);
        end
    endgenerate

    assign w_upd_elig = bus.upd_req;
    assign w_wr_elig  = bus.wr_req && (!WR_VBLANK_ONLY || bus.vblank);
    assign w_upd_ovr  = w_upd_elig && (r_upd_cnt == c_LIMIT);
    assign w_wr_ovr   = w_wr_elig  && (r_wr_cnt  == c_LIMIT);

    always_comb begin
        w_upd_gnt   = 1'b0;
        w_wr_gnt    = 1'b0;
        w_disp_gnt  = 1'b0;
        w_disp_miss = 1'b0;
        w_override  = 1'b0;
        w_rr_next   = r_rr;
        if (!reset) begin
            if (w_upd_ovr || w_wr_ovr) begin
                w_override  = 1'b1;
                w_disp_miss = bus.disp_req;
                if (w_upd_ovr && w_wr_ovr) begin
                    w_upd_gnt = (r_rr == RR_UPD);
                    w_wr_gnt  = (r_rr == RR_WR);
                end else begin
                    w_upd_gnt = w_upd_ovr;
                    w_wr_gnt  = w_wr_ovr;
                end
            end else if (bus.disp_req) begin
                w_disp_gnt = 1'b1;
            end else if (w_upd_elig && w_wr_elig) begin
                // Winner takes the slot, pointer moves to the loser.
                if (r_rr == RR_UPD) begin
                    w_upd_gnt = 1'b1;
                    w_rr_next = RR_WR;
                end else begin
                    w_wr_gnt  = 1'b1;
                    w_rr_next = RR_UPD;
                end
            end else begin
                w_upd_gnt = w_upd_elig;
                w_wr_gnt  = w_wr_elig;
            end
        end
    end

    always_comb begin
        w_upd_cnt_next = '0;
        w_wr_cnt_next  = '0;
        if (w_upd_elig && !w_upd_gnt)
            w_upd_cnt_next = (r_upd_cnt == c_LIMIT) ? r_upd_cnt : r_upd_cnt + 1'b1;
        if (w_wr_elig && !w_wr_gnt)
            w_wr_cnt_next = (r_wr_cnt == c_LIMIT) ? r_wr_cnt : r_wr_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cells      <= '0;
            r_rr         <= RR_UPD;
            r_upd_cnt    <= '0;
            r_wr_cnt     <= '0;
            r_disp_data  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_upd_data   <= 1'b0;
            r_upd_valid  <= 1'b0;
            r_starve     <= 1'b0;
        end else begin
            r_rr         <= w_rr_next;
            r_upd_cnt    <= w_upd_cnt_next;
            r_wr_cnt     <= w_wr_cnt_next;
            r_disp_valid <= w_disp_gnt;
            r_upd_valid  <= w_upd_gnt;
            if (w_wr_gnt && w_wr_in)
                r_cells[w_wr_idx] <= bus.wr_data;
            if (w_disp_gnt)
                r_disp_data <= w_disp_in && r_cells[w_disp_idx];
            if (w_upd_gnt)
                r_upd_data <= w_upd_in && r_cells[w_upd_idx];
            if (w_override)
                r_starve <= 1'b1;
        end
    end

    assign bus.disp_data   = r_disp_data;
    assign bus.disp_valid  = r_disp_valid;
    assign bus.disp_miss   = w_disp_miss;
    assign bus.upd_gnt     = w_upd_gnt;
    assign bus.upd_data    = r_upd_data;
    assign bus.upd_valid   = r_upd_valid;
    assign bus.wr_gnt      = w_wr_gnt;
    assign bus.starve_flag = r_starve;
endmodule
`default_nettype wire

// File: tb/tb_life_board_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_life_board_arbiter
// Brief    : Directed and randomized bench against a priority-rule board model
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_life_board_arbiter;
    localparam int c_ADDR_W = 8;
    localparam int c_DEPTH  = 128;
    localparam int c_LIMIT  = 15;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    life_board_arbiter_if #(.ADDR_W(c_ADDR_W)) bus ();

    life_board_arbiter #(
        .ADDR_W(c_ADDR_W),
        .DEPTH(c_DEPTH),
        .STARVE_LIMIT(c_LIMIT),
        .WR_VBLANK_ONLY(1'b1)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit m_cells [c_DEPTH];
    int m_ucnt, m_wcnt;
    int m_rr;          // 1 = update next, 2 = write next
    bit m_starve, m_dv, m_dd, m_uv, m_ud;
    int last_win;      // 0 none, 1 update, 2 write

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit cell_at(input int addr);
        return (addr < c_DEPTH) ? m_cells[addr] : 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_DEPTH; i++) m_cells[i] = 1'b0;
        m_ucnt = 0; m_wcnt = 0; m_rr = 1;
        m_starve = 0; m_dv = 0; m_dd = 0; m_uv = 0; m_ud = 0;
    endtask

    // One clock cycle: check grants mid-cycle, advance model, check registered outputs.
    task automatic cycle();
        int  win;
        bit  ue, we, uo, wo, ovr, dgnt, miss;
        @(negedge clk);
        win = 0; dgnt = 0; miss = 0; ovr = 0;
        ue = bus.upd_req;
        we = bus.wr_req && bus.vblank;
        uo = ue && (m_ucnt == c_LIMIT);
        wo = we && (m_wcnt == c_LIMIT);
        if (!reset) begin
            if (uo || wo) begin
                ovr  = 1;
                miss = bus.disp_req;
                win  = (uo && wo) ? m_rr : (uo ? 1 : 2);
            end else if (bus.disp_req) begin
                dgnt = 1;
            end else if (ue && we) begin
                win  = m_rr;
                m_rr = 3 - m_rr;
            end else if (ue) begin
                win = 1;
            end else if (we) begin
                win = 2;
            end
        end
        check("upd_gnt", bus.upd_gnt, win == 1);
        check("wr_gnt", bus.wr_gnt, win == 2);
        check("disp_miss", bus.disp_miss, miss);
        last_win = win;
        if (reset) begin
            model_reset();
        end else begin
            m_dv = dgnt;
            if (dgnt) m_dd = cell_at(int'(bus.disp_addr));
            m_uv = (win == 1);
            if (win == 1) m_ud = cell_at(int'(bus.upd_addr));
            if (win == 2 && bus.wr_addr < c_DEPTH) m_cells[bus.wr_addr] = bus.wr_data;
            m_ucnt = (ue && win != 1) ? ((m_ucnt < c_LIMIT) ? m_ucnt + 1 : m_ucnt) : 0;
            m_wcnt = (we && win != 2) ? ((m_wcnt < c_LIMIT) ? m_wcnt + 1 : m_wcnt) : 0;
            if (ovr) m_starve = 1;
        end
        @(posedge clk);
        #1;
        check("disp_valid", bus.disp_valid, m_dv);
        check("disp_data", bus.disp_data, m_dd);
        check("upd_valid", bus.upd_valid, m_uv);
        check("upd_data", bus.upd_data, m_ud);
        check("starve_flag", bus.starve_flag, m_starve);
    endtask

    task automatic idle();
        bus.disp_req = 0; bus.upd_req = 0; bus.wr_req = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; last_win = 0;
        model_reset();
        reset = 1;
        bus.vblank = 0; bus.disp_req = 0; bus.disp_addr = '0;
        bus.upd_req = 0; bus.upd_addr = '0;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = 0;
        cycle();
        cycle();
        reset = 0;

        // Sweep the cleared board through the display port
        for (int a = 0; a < c_DEPTH; a++) begin
            bus.disp_req = 1; bus.disp_addr = c_ADDR_W'(a);
            cycle();
        end
        idle();
        cycle();

        // Write in vblank then read back through display
        bus.vblank = 1;
        bus.wr_req = 1; bus.wr_addr = 8'd5; bus.wr_data = 1;
        cycle();
        bus.wr_req = 0;
        bus.disp_req = 1; bus.disp_addr = 8'd5;
        cycle();
        idle();
        cycle();

        // Writes gated outside vblank do not starve
        bus.vblank = 0;
        bus.wr_req = 1; bus.wr_addr = 8'd9; bus.wr_data = 1;
        for (int i = 0; i < 40; i++) cycle();
        bus.vblank = 1;
        cycle();
        idle();
        cycle();

        // Round-robin from reset: upd first, then alternating
        do_reset();
        bus.vblank = 1;
        bus.upd_req = 1; bus.upd_addr = 8'd5;
        bus.wr_req = 1; bus.wr_addr = 8'd7; bus.wr_data = 1;
        for (int i = 0; i < 8; i++) cycle();
        idle();
        cycle();

        // Display starves update until the override fires
        bus.disp_req = 1; bus.disp_addr = 8'd7;
        bus.upd_req = 1; bus.upd_addr = 8'd7;
        for (int i = 0; i < 20; i++) cycle();
        idle();
        cycle();

        // Randomized traffic honouring the hold-until-grant handshake
        for (int i = 0; i < 3000; i++) begin
            if (!(bus.upd_req && last_win != 1 && $urandom_range(0, 15) != 0)) begin
                bus.upd_req  = ($urandom_range(0, 2) != 0);
                bus.upd_addr = c_ADDR_W'($urandom_range(0, 139));
            end
            if (!(bus.wr_req && last_win != 2 && $urandom_range(0, 15) != 0)) begin
                bus.wr_req  = ($urandom_range(0, 2) != 0);
                bus.wr_addr = c_ADDR_W'($urandom_range(0, 139));
                bus.wr_data = $urandom_range(0, 1);
            end
            bus.disp_req  = ($urandom_range(0, 3) != 0);
            bus.disp_addr = c_ADDR_W'($urandom_range(0, 139));
            if ($urandom_range(0, 19) == 0) bus.vblank = ~bus.vblank;
            cycle();
        end
        idle();
        cycle();

        // Out-of-range update read, then reset right after an update grant
        bus.upd_req = 1; bus.upd_addr = 8'd130;
        cycle();
        bus.upd_addr = 8'd9;
        cycle();
        do_reset();
        for (int a = 0; a < c_DEPTH; a++) begin
            bus.disp_req = 1; bus.disp_addr = c_ADDR_W'(a);
            cycle();
        end
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
